commit_trace_buf: RTL
=====================

COMMIT_TRACE_BUF -- requirements
Module: commit_trace_buf

Interface
REQ-001 Parameter XLEN, default 32, data/address width of trace fields.
REQ-002 Parameter DEPTH, default 16, record entries; power of two, >=2.
REQ-003 Parameter OVERWRITE, default 0; 0 = drop new record when full, 1 = overwrite oldest.
REQ-004 Parameter CNT_W, default 32, width of retire_cnt and drop_cnt.
REQ-005 Clock and reset: one clock; reset is synchronous and active-high.
REQ-006 clk  in  1  clock; all state changes on posedge.
REQ-007 rst  in  1  reset.
REQ-008 global_en  in  1  capture enable; 0 freezes capture side only.
REQ-009 clr  in  1  single-cycle clear: empties buffer, clears flags and counters, returns to RUN.
REQ-010 commit, commit_halt, commit_reg_we, commit_dmem_we  in  1 each  commit-record valid and flags.
REQ-011 commit_pc, commit_inst, commit_reg_wd, commit_dmem_wa, commit_dmem_wd  in  XLEN each  record fields; commit_reg_wa  in  5.
REQ-012 rd_valid  out  1  head record present; rd_ready  in  1  consumer accepts head.
REQ-013 rd_pc, rd_inst, rd_reg_wd, rd_dmem_wa, rd_dmem_wd  out  XLEN; rd_reg_wa  out  5; rd_halt, rd_reg_we, rd_dmem_we  out  1: head record fields.
REQ-014 count  out  log2(DEPTH)+1  occupied entries.
REQ-015 overflow  out  1  sticky: at least one record dropped or overwritten.
REQ-016 halted  out  1  halt record captured; drained  out  1  halted and buffer empty.
REQ-017 retire_cnt, drop_cnt  out  CNT_W  accepted commits / lost records.

Function
REQ-018 States RUN, HALTED, DRAINED; RUN->HALTED on capture of a record with commit_halt=1; HALTED->DRAINED when count reaches 0; DRAINED/HALTED->RUN only by clr or rst.
REQ-019 Push condition: state RUN and global_en=1 and commit=1; record (all fields) written at write pointer.
REQ-020 Commits while HALTED or DRAINED, or with global_en=0, are ignored: no write, no counter change.
REQ-021 retire_cnt increments by 1 on every push condition, including dropped ones; wraps modulo 2^CNT_W.
REQ-022 Pop: rd_valid=1 and rd_ready=1; head advances next edge; independent of global_en and state.
REQ-023 rd_valid = (count != 0); rd_* fields are the head record, first-word-fall-through, undefined content when rd_valid=0 is not checked.
REQ-024 Write-to-read latency: record pushed at edge N visible on rd_* and rd_valid at cycle after edge N; no same-cycle bypass from commit inputs.
REQ-025 Full (count=DEPTH), push, no pop, OVERWRITE=0: record discarded, drop_cnt +1 saturating at all-ones, overflow set, count unchanged; if that record has halt=1, state still moves to HALTED.
REQ-026 Full, push, no pop, OVERWRITE=1: record written, oldest discarded (read pointer advances), drop_cnt +1 saturating, overflow set, count stays DEPTH.
REQ-027 Full, push and pop same cycle: both performed in either mode, no drop, count unchanged.
REQ-028 Empty, push and rd_ready=1 same cycle: no pop (rd_valid=0), count becomes 1.
REQ-029 Pointers log2(DEPTH) bits, wrap modulo DEPTH; count tracked separately to distinguish full/empty.
REQ-030 halted = state in {HALTED, DRAINED}; drained = state DRAINED.
REQ-031 clr has priority over simultaneous push/pop: buffer empty, counters 0, overflow 0, state RUN next cycle; the cycle's commit is not captured.

Reset
REQ-032 rst=1 on a posedge: count=0, pointers=0, rd_valid=0, overflow=0, halted=0, drained=0, retire_cnt=0, drop_cnt=0, state RUN; rst overrides clr, global_en and rd_ready.
REQ-033 Reset mid-operation discards all stored records; first commit after deassertion is captured normally.

Verification
REQ-034 DEPTH=4: push 3 records pc=0x0,0x4,0x8, rd_ready=0 -> count=3, rd_pc=0x0; then rd_ready=1 three cycles -> rd_pc 0x0,0x4,0x8, count=0, rd_valid=0.
REQ-035 DEPTH=4, OVERWRITE=0: 6 pushes pc=0x0..0x14, no pops -> count=4, drop_cnt=2, overflow=1, retire_cnt=6, drained order 0x0,0x4,0x8,0xC.
REQ-036 DEPTH=4, OVERWRITE=1: same stimulus -> drop_cnt=2, overflow=1, drained order 0x8,0xC,0x10,0x14.
REQ-037 Push 2 records then inst=0x80000000 with commit_halt=1, then 3 more commits -> retire_cnt=3, halted=1, count=3; drain -> drained=1 after third pop; clr -> state RUN, all counters 0.
REQ-038 Full buffer with simultaneous push+pop -> count stays 4, drop_cnt=0; global_en=0 with commit=1 for 5 cycles -> no count or retire_cnt change; rst mid-stream -> count=0, rd_valid=0 next cycle.

Source files
------------

// File: rtl/commit_trace_buf.sv
// Commit trace buffer: captures retired-instruction records into a small
// FIFO. The head record is shown first-word-fall-through on rd_*. A small
// RUN/HALTED/DRAINED state machine stops capture once a halt record is seen.
module commit_trace_buf #(
    parameter int XLEN      = 32,
    parameter int DEPTH     = 16,
    parameter int OVERWRITE = 0,
    parameter int CNT_W     = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     global_en,
    input  logic                     clr,
    input  logic                     commit,
    input  logic                     commit_halt,
    input  logic                     commit_reg_we,
    input  logic                     commit_dmem_we,
    input  logic [XLEN-1:0]          commit_pc,
    input  logic [XLEN-1:0]          commit_inst,
    input  logic [4:0]               commit_reg_wa,
    input  logic [XLEN-1:0]          commit_reg_wd,
    input  logic [XLEN-1:0]          commit_dmem_wa,
    input  logic [XLEN-1:0]          commit_dmem_wd,
    output logic                     rd_valid,
    input  logic                     rd_ready,
    output logic [XLEN-1:0]          rd_pc,
    output logic [XLEN-1:0]          rd_inst,
    output logic [4:0]               rd_reg_wa,
    output logic [XLEN-1:0]          rd_reg_wd,
    output logic [XLEN-1:0]          rd_dmem_wa,
    output logic [XLEN-1:0]          rd_dmem_wd,
    output logic                     rd_halt,
    output logic                     rd_reg_we,
    output logic                     rd_dmem_we,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     halted,
    output logic                     drained,
    output logic [CNT_W-1:0]         retire_cnt,
    output logic [CNT_W-1:0]         drop_cnt
);

    localparam int AW    = $clog2(DEPTH);
    localparam int REC_W = 5 * XLEN + 5 + 3;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_HALTED  = 2'd1,
        ST_DRAINED = 2'd2
    } state_t;

    // Record storage; no reset, the pointers and count define what is valid.
    logic [REC_W-1:0] mem [DEPTH];

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    state_t           state_q, state_d;
    logic             overflow_q, overflow_d;
    logic [CNT_W-1:0] retire_cnt_q, retire_cnt_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    logic             push;
    logic             pop;
    logic             full;
    logic             drop_rec;
    logic             ow_drop;
    logic             wr_en;
    logic             cnt_inc;
    logic [REC_W-1:0] wr_rec;
    logic [REC_W-1:0] rd_rec;

    assign wr_rec = {commit_halt, commit_reg_we, commit_dmem_we, commit_reg_wa,
                     commit_pc, commit_inst, commit_reg_wd, commit_dmem_wa,
                     commit_dmem_wd};

    // Head record is read combinationally so a push is visible right after its edge.
    assign rd_rec = mem[rd_ptr_q];
    assign {rd_halt, rd_reg_we, rd_dmem_we, rd_reg_wa, rd_pc, rd_inst,
            rd_reg_wd, rd_dmem_wa, rd_dmem_wd} = rd_rec;

    assign rd_valid   = (count_q != '0);
    assign count      = count_q;
    assign overflow   = overflow_q;
    assign halted     = (state_q != ST_RUN);
    assign drained    = (state_q == ST_DRAINED);
    assign retire_cnt = retire_cnt_q;
    assign drop_cnt   = drop_cnt_q;

    // Next-state: push/pop/drop decisions, pointer and counter updates, FSM.
    always_comb begin
        full     = (count_q == FULL_CNT);
        push     = (state_q == ST_RUN) && global_en && commit;
        pop      = (count_q != '0) && rd_ready;
        // A push into a full buffer with no pop loses a record one way or the other.
        drop_rec = push && full && !pop;
        ow_drop  = drop_rec && (OVERWRITE != 0);
        wr_en    = push && (!drop_rec || ow_drop);
        // In overwrite the write and the discarded oldest cancel out in count.
        cnt_inc  = wr_en && !ow_drop;

        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q + (AW+1)'(cnt_inc) - (AW+1)'(pop);
        overflow_d   = overflow_q;
        retire_cnt_d = retire_cnt_q;
        drop_cnt_d   = drop_cnt_q;
        state_d      = state_q;

        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop || ow_drop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push) begin
            retire_cnt_d = retire_cnt_q + CNT_W'(1);
        end
        if (drop_rec) begin
            overflow_d = 1'b1;
            if (drop_cnt_q != '1) begin
                drop_cnt_d = drop_cnt_q + CNT_W'(1);
            end
        end

        case (state_q)
            ST_RUN: begin
                // A dropped halt record still stops capture.
                if (push && commit_halt) begin
                    state_d = ST_HALTED;
                end
            end
            ST_HALTED: begin
                if (count_d == '0) begin
                    state_d = ST_DRAINED;
                end
            end
            default: begin
                state_d = state_q;
            end
        endcase

        // Clear wins over anything else happening this cycle.
        if (clr) begin
            wr_en        = 1'b0;
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
            count_d      = '0;
            overflow_d   = 1'b0;
            retire_cnt_d = '0;
            drop_cnt_d   = '0;
            state_d      = ST_RUN;
        end
    end

    // Control state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            overflow_q   <= 1'b0;
            retire_cnt_q <= '0;
            drop_cnt_q   <= '0;
            state_q      <= ST_RUN;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            overflow_q   <= overflow_d;
            retire_cnt_q <= retire_cnt_d;
            drop_cnt_q   <= drop_cnt_d;
            state_q      <= state_d;
        end
    end

    // Record write port.
    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            mem[wr_ptr_q] <= wr_rec;
        end
    end

endmodule
